md_ctrl: RTL and testbench

Multiply/divide sequencing controller for the five-stage MIPS core. It sits beside the E stage and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued there. It models fixed multi-cycle latency with a busy counter, owns the HI/LO architectural registers, and drives the stall request the hazard logic uses to freeze F/D while a D-stage HI/LO-dependent instruction must wait.

---
 rtl/md_ctrl_pkg.sv | 27 ++
 rtl/md_alu.sv | 58 +++++
 rtl/md_ctrl.sv | 141 ++++++++++++++
 tb/tb_md_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, latency
// defaults and the long-op classifier used by md_ctrl, decode and hazard logic.
package md_ctrl_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_e;

   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;

   // Busy counter width; must hold the larger of the two latencies.
   localparam int MD_CNT_W = 4;

   // True for the ops that occupy the unit for several cycles.
   function automatic logic md_is_long(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational arithmetic core: one 64-bit multiply and a 32-bit divide,
// both selectable signed/unsigned, with overflow and zero-divisor flags.
module md_alu (
   input  logic        i_signed,
   input  logic [31:0] i_rs,
   input  logic [31:0] i_rt,
   output logic [63:0] o_prod,
   output logic [31:0] o_quo,
   output logic [31:0] o_rem,
   output logic        o_ovf,
   output logic        o_div0
);

   // Negate a magnitude when the signed result must be negative.
   function automatic logic [31:0] apply_sign(input logic [31:0] mag, input logic neg);
      return neg ? (~mag + 32'd1) : mag;
   endfunction

   logic signed [63:0] w_a;
   logic signed [63:0] w_b;
   logic signed [63:0] w_prod;
   logic               w_a_neg;
   logic               w_b_neg;
   logic        [31:0] w_a_mag;
   logic        [31:0] w_b_mag;
   logic        [31:0] w_uq;
   logic        [31:0] w_ur;

   // Extending by the signedness lets one 64x64 multiplier serve MULT and MULTU;
   // the low 64 bits of the product are exact in both cases.
   assign w_a    = {{32{i_signed & i_rs[31]}}, i_rs};
   assign w_b    = {{32{i_signed & i_rt[31]}}, i_rt};
   assign w_prod = w_a * w_b;
   assign o_prod = w_prod;

   assign w_a_neg = i_signed & i_rs[31];
   assign w_b_neg = i_signed & i_rt[31];
   assign w_a_mag = apply_sign(i_rs, w_a_neg);
   assign w_b_mag = apply_sign(i_rt, w_b_neg);

   assign o_div0 = (i_rt == 32'd0);
   assign o_ovf  = i_signed & (i_rs == 32'h8000_0000) & (i_rt == 32'hFFFF_FFFF);

   // Divide on magnitudes so truncation is toward zero; a zero divisor yields 0.
   always_comb begin
      w_uq = 32'd0;
      w_ur = 32'd0;
      if (!o_div0) begin
         w_uq = w_a_mag / w_b_mag;
         w_ur = w_a_mag % w_b_mag;
      end
   end

   // Quotient sign follows the operand signs, remainder follows the dividend.
   assign o_quo = apply_sign(w_uq, w_a_neg ^ w_b_neg);
   assign o_rem = apply_sign(w_ur, w_a_neg);

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: fixed-latency busy counter, HI/LO ownership
// and the F/D stall request for HI/LO-dependent instructions in D.
module md_ctrl
   import md_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        d_is_md,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [MD_CNT_W-1:0] L_MULT_CNT = MD_CNT_W'(MULT_CYCLES);
   localparam logic [MD_CNT_W-1:0] L_DIV_CNT  = MD_CNT_W'(DIV_CYCLES);
   localparam logic [MD_CNT_W-1:0] L_CNT_ONE  = MD_CNT_W'(1);

   md_op_e              w_op;
   logic                w_signed;
   logic [63:0]         w_prod;
   logic [31:0]         w_quo;
   logic [31:0]         w_rem;
   logic                w_ovf;
   logic                w_div0;

   logic [MD_CNT_W-1:0] r_cnt;
   logic                r_pend_valid;
   logic [31:0]         r_pend_hi;
   logic [31:0]         r_pend_lo;
   logic [31:0]         r_hi;
   logic [31:0]         r_lo;

   logic [MD_CNT_W-1:0] w_cnt_nxt;
   logic                w_pv_nxt;
   logic                w_pend_ld;
   logic [31:0]         w_pend_hi_nxt;
   logic [31:0]         w_pend_lo_nxt;
   logic [31:0]         w_hi_nxt;
   logic [31:0]         w_lo_nxt;

   assign w_op     = md_op_e'(md_op);
   assign w_signed = (w_op == MD_MULT) || (w_op == MD_DIV);

   md_alu u_alu (
      .i_signed (w_signed),
      .i_rs     (rs_val),
      .i_rt     (rt_val),
      .o_prod   (w_prod),
      .o_quo    (w_quo),
      .o_rem    (w_rem),
      .o_ovf    (w_ovf),
      .o_div0   (w_div0)
   );

   // State register: counter, pending flag and architectural HI/LO.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt        <= '0;
         r_pend_valid <= 1'b0;
         r_hi         <= 32'd0;
         r_lo         <= 32'd0;
      end else begin
         r_cnt        <= w_cnt_nxt;
         r_pend_valid <= w_pv_nxt;
         r_hi         <= w_hi_nxt;
         r_lo         <= w_lo_nxt;
      end
   end

   // Pending result capture; qualified by r_pend_valid so it needs no reset.
   always_ff @(posedge clk) begin
      if (w_pend_ld) begin
         r_pend_hi <= w_pend_hi_nxt;
         r_pend_lo <= w_pend_lo_nxt;
      end
   end

   // Next state: accept ops only while idle, count down and commit on 1->0.
   always_comb begin
      w_cnt_nxt     = r_cnt;
      w_pv_nxt      = r_pend_valid;
      w_hi_nxt      = r_hi;
      w_lo_nxt      = r_lo;
      w_pend_ld     = 1'b0;
      w_pend_hi_nxt = w_prod[63:32];
      w_pend_lo_nxt = w_prod[31:0];
      if (r_cnt == '0) begin
         if (start) begin
            case (w_op)
               MD_MULT, MD_MULTU: begin
                  w_pend_ld = 1'b1;
                  w_cnt_nxt = L_MULT_CNT;
                  w_pv_nxt  = 1'b1;
               end
               MD_DIV, MD_DIVU: begin
                  w_pend_ld     = 1'b1;
                  w_pend_hi_nxt = w_rem;
                  w_pend_lo_nxt = w_quo;
                  // The most-negative / -1 case saturates to itself with no remainder.
                  if (w_ovf) begin
                     w_pend_hi_nxt = 32'd0;
                     w_pend_lo_nxt = 32'h8000_0000;
                  end
                  w_cnt_nxt = L_DIV_CNT;
                  // A zero divisor still costs the full latency but never commits.
                  w_pv_nxt  = !w_div0;
               end
               MD_MTHI: w_hi_nxt = rs_val;
               MD_MTLO: w_lo_nxt = rs_val;
               default: ;
            endcase
         end
      end else begin
         w_cnt_nxt = r_cnt - L_CNT_ONE;
         if (r_cnt == L_CNT_ONE) begin
            if (r_pend_valid) begin
               w_hi_nxt = r_pend_hi;
               w_lo_nxt = r_pend_lo;
            end
            w_pv_nxt = 1'b0;
         end
      end
   end

   // Outputs: busy from the counter, stall also covers a long op issuing now.
   always_comb begin
      busy  = (r_cnt != '0);
      stall = d_is_md & (busy | (start & md_is_long(md_op)));
      hi    = r_hi;
      lo    = r_lo;
   end

endmodule

// File: tb/tb_md_ctrl.sv
// Bench for md_ctrl: directed and random ops, a time-based reference model
// feeding a per-cycle expectation queue, and an independent monitor.
module tb_md_ctrl;
   import md_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  md_op = 3'd0;
   logic [31:0] rs_val = 32'd0;
   logic [31:0] rt_val = 32'd0;
   logic        d_is_md = 1'b0;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   md_ctrl dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .md_op   (md_op),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .d_is_md (d_is_md),
      .busy    (busy),
      .stall   (stall),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic        busy;
      logic        stall;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   typedef struct {
      int          cyc;
      logic [31:0] hi;
      logic [31:0] lo;
   } fix_t;

   exp_t expq[$];
   fix_t fixq[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model state, expressed in absolute cycle numbers.
   int          cyc = 0;
   int          busy_end = -1;
   bit          wr_pend = 1'b0;
   int          wr_cyc = 0;
   bit          wr_hi_en = 1'b0;
   bit          wr_lo_en = 1'b0;
   logic [31:0] wr_hi = 32'd0;
   logic [31:0] wr_lo = 32'd0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   bit          armed = 1'b0;

   task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, c, act, req);
      end
   endtask

   task automatic fix_hl(input int c, input logic [31:0] h, input logic [31:0] l);
      fix_t f;
      f.cyc = c;
      f.hi  = h;
      f.lo  = l;
      fixq.push_back(f);
   endtask

   // Schedule a HI/LO result that becomes visible n+1 cycles after issue.
   task automatic sched(input int n, input logic [31:0] h, input logic [31:0] l);
      busy_end = cyc + n;
      wr_pend  = 1'b1;
      wr_cyc   = cyc + n + 1;
      wr_hi_en = 1'b1;
      wr_lo_en = 1'b1;
      wr_hi    = h;
      wr_lo    = l;
   endtask

   // One clock cycle: drive inputs, record expected outputs, advance the model.
   task automatic step(input bit rstn, input bit st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input bit dmd);
      exp_t              e;
      bit                bsy;
      bit                lng;
      int                sa;
      int                sb;
      longint            sp;
      longint unsigned   ua;
      longint unsigned   ub;
      longint unsigned   up;
      logic [31:0]       q;
      logic [31:0]       r;
      @(posedge clk);
      #1;
      cyc++;
      if (wr_pend && wr_cyc == cyc) begin
         if (wr_hi_en) m_hi = wr_hi;
         if (wr_lo_en) m_lo = wr_lo;
         wr_pend = 1'b0;
      end
      bsy = (cyc <= busy_end);
      if (bsy) st = 1'b0;
      reset   = rstn;
      start   = st;
      md_op   = op;
      rs_val  = a;
      rt_val  = b;
      d_is_md = dmd;
      lng = st && (op >= 3'd1) && (op <= 3'd4);
      e.cyc   = cyc;
      e.busy  = bsy;
      e.stall = dmd && (bsy || lng);
      e.hi    = m_hi;
      e.lo    = m_lo;
      if (armed) expq.push_back(e);
      if (!rstn) begin
         busy_end = cyc;
         wr_pend  = 1'b1;
         wr_cyc   = cyc + 1;
         wr_hi_en = 1'b1;
         wr_lo_en = 1'b1;
         wr_hi    = 32'd0;
         wr_lo    = 32'd0;
         armed    = 1'b1;
      end else if (st) begin
         sa = a;
         sb = b;
         case (op)
            MD_MULT: begin
               sp = longint'(sa) * longint'(sb);
               sched(MD_MULT_CYCLES, sp[63:32], sp[31:0]);
            end
            MD_MULTU: begin
               ua = {32'd0, a};
               ub = {32'd0, b};
               up = ua * ub;
               sched(MD_MULT_CYCLES, up[63:32], up[31:0]);
            end
            MD_DIV: begin
               if (b == 32'd0) begin
                  busy_end = cyc + MD_DIV_CYCLES;
               end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                  sched(MD_DIV_CYCLES, 32'd0, 32'h8000_0000);
               end else begin
                  q = sa / sb;
                  r = sa % sb;
                  sched(MD_DIV_CYCLES, r, q);
               end
            end
            MD_DIVU: begin
               if (b == 32'd0) begin
                  busy_end = cyc + MD_DIV_CYCLES;
               end else begin
                  sched(MD_DIV_CYCLES, a % b, a / b);
               end
            end
            MD_MTHI: begin
               wr_pend = 1'b1; wr_cyc = cyc + 1; wr_hi_en = 1'b1; wr_lo_en = 1'b0; wr_hi = a;
            end
            MD_MTLO: begin
               wr_pend = 1'b1; wr_cyc = cyc + 1; wr_hi_en = 1'b0; wr_lo_en = 1'b1; wr_lo = a;
            end
            default: ;
         endcase
      end
   endtask

   task automatic idle(input int n, input bit dmd);
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, dmd);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: compare every recorded cycle at the falling edge.
   initial begin : monitor
      exp_t e;
      fix_t f;
      forever begin
         @(negedge clk);
         if (armed && start && busy) begin
            miscompares++;
            $display("FAIL start_while_busy cyc=%0d actual=start required=no start", cyc);
         end
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("busy",  e.cyc, 32'(busy),  32'(e.busy));
            chk("stall", e.cyc, 32'(stall), 32'(e.stall));
            chk("hi",    e.cyc, hi, e.hi);
            chk("lo",    e.cyc, lo, e.lo);
            while (fixq.size() > 0 && fixq[0].cyc <= e.cyc) begin
               f = fixq.pop_front();
               chk("fixed_hi", f.cyc, (f.cyc == e.cyc) ? hi : 32'hDEAD_BEEF, f.hi);
               chk("fixed_lo", f.cyc, (f.cyc == e.cyc) ? lo : 32'hDEAD_BEEF, f.lo);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int s;
      bit rn;
      bit st;
      bit dm;
      logic [2:0] op;
      logic [31:0] a;
      logic [31:0] b;

      step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
      idle(1, 1'b0);

      // MULT -2*3 with MFLO waiting in D.
      step(1'b1, 1'b1, MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1); s = cyc;
      fix_hl(s + MD_MULT_CYCLES + 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      idle(MD_MULT_CYCLES, 1'b1);

      // MULTU same operands, no dependent instruction in D.
      step(1'b1, 1'b1, MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0); s = cyc;
      fix_hl(s + MD_MULT_CYCLES + 1, 32'h0000_0002, 32'hFFFF_FFFA);
      idle(MD_MULT_CYCLES, 1'b0);

      step(1'b1, 1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1); s = cyc;
      fix_hl(s + MD_DIV_CYCLES + 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      idle(MD_DIV_CYCLES, 1'b1);

      // Zero divisor: full latency, HI/LO untouched.
      step(1'b1, 1'b1, MD_DIVU, 32'd7, 32'd0, 1'b0); s = cyc;
      fix_hl(s + MD_DIV_CYCLES + 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      idle(MD_DIV_CYCLES, 1'b0);

      step(1'b1, 1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); s = cyc;
      fix_hl(s + MD_DIV_CYCLES + 1, 32'd0, 32'h8000_0000);
      idle(MD_DIV_CYCLES, 1'b0);

      step(1'b1, 1'b1, MD_MTHI, 32'h0000_1234, 32'd0, 1'b1); s = cyc;
      fix_hl(s + 1, 32'h0000_1234, 32'h8000_0000);

      step(1'b1, 1'b1, MD_DIVU, 32'd100, 32'd7, 1'b0); s = cyc;
      fix_hl(s + MD_DIV_CYCLES + 1, 32'd2, 32'd14);
      idle(MD_DIV_CYCLES, 1'b0);

      // Reset while the counter sits at 1: nothing commits.
      step(1'b1, 1'b1, MD_DIV, 32'd1000, 32'd7, 1'b0); s = cyc;
      idle(MD_DIV_CYCLES - 1, 1'b0);
      step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      fix_hl(s + MD_DIV_CYCLES + 1, 32'd0, 32'd0);
      idle(2, 1'b0);

      // Random traffic; starts are suppressed by the model while busy.
      for (int i = 0; i < 600; i++) begin
         rn = ($urandom_range(0, 63) != 0);
         st = ($urandom_range(0, 2) == 0);
         dm = ($urandom_range(0, 1) == 1);
         op = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         step(rn, st, op, a, b, dm);
      end
      idle(2, 1'b0);

      @(posedge clk);
      @(posedge clk);
      vectors++;
      if (expq.size() != 0 || fixq.size() != 0) begin
         miscompares++;
         $display("FAIL drain cyc=%0d actual=%0d pending required=0 pending", cyc, expq.size() + fixq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
